// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, register names and arbiter state encoding for
// the register-file write-port arbiter and its scoreboard.
package regfile_pkg;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NREGS = 32;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;
  localparam logic [AW-1:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: pipeline-side bus of the write-port arbiter.
//   WB writer    : wb_valid, wb_reg, wb_data -> wb_hold
//   LU issue     : lu_issue, lu_issue_reg    -> lu_issue_ok
//   LU result    : lu_valid, lu_reg, lu_data -> lu_ready
//   Decode hazard: rd_reg_1, rd_reg_2        -> hazard_stall
// master = pipeline/LU side, slave = arbiter.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic          wb_valid;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic          wb_hold;

  logic          lu_issue;
  logic [AW-1:0] lu_issue_reg;
  logic          lu_issue_ok;

  logic          lu_valid;
  logic [AW-1:0] lu_reg;
  logic [DW-1:0] lu_data;
  logic          lu_ready;

  logic [AW-1:0] rd_reg_1;
  logic [AW-1:0] rd_reg_2;
  logic          hazard_stall;

  modport master (
    output wb_valid, wb_reg, wb_data, lu_issue, lu_issue_reg,
           lu_valid, lu_reg, lu_data, rd_reg_1, rd_reg_2,
    input  wb_hold, lu_issue_ok, lu_ready, hazard_stall
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, lu_issue, lu_issue_reg,
           lu_valid, lu_reg, lu_data, rd_reg_1, rd_reg_2,
    output wb_hold, lu_issue_ok, lu_ready, hazard_stall
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write bit per architectural register for
// long-latency-unit destinations.
//   clk, reset      : clock, async active-high reset (clears all bits)
//   lu_issue/_reg   : decode issuing an LU op and its destination
//   lu_xfer/lu_reg  : LU result accepted this cycle and its destination
//   rd_reg_1/2      : decode source registers
//   pending         : scoreboard bits
//   lu_issue_ok     : issue allowed (no outstanding write to the same dest)
//   hazard_stall    : a decode source is still pending
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             lu_issue,
  input  logic [AW-1:0]    lu_issue_reg,
  input  logic             lu_xfer,
  input  logic [AW-1:0]    lu_reg,
  input  logic [AW-1:0]    rd_reg_1,
  input  logic [AW-1:0]    rd_reg_2,
  output logic [NREGS-1:0] pending,
  output logic             lu_issue_ok,
  output logic             hazard_stall
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_nx;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  logic             issue_ok_raw;

  // A source retiring through the write port this cycle is forwarded by the
  // register file, so it does not need to stall.
  function automatic logic src_hazard(input logic [AW-1:0] r,
                                      input logic [NREGS-1:0] pend,
                                      input logic xfer,
                                      input logic [AW-1:0] xfer_reg);
    return (r != REG_ZERO) && pend[r] && !(xfer && (xfer_reg == r));
  endfunction

  always_comb begin
    issue_ok_raw = (lu_issue_reg == REG_ZERO) || !pending_q[lu_issue_reg] ||
                   (lu_xfer && (lu_reg == lu_issue_reg));
    set_mask = '0;
    if (lu_issue && issue_ok_raw && (lu_issue_reg != REG_ZERO))
      set_mask = NREGS'(1) << lu_issue_reg;
    clr_mask = '0;
    if (lu_xfer)
      clr_mask = NREGS'(1) << lu_reg;
    // Set applied after clear: a same-cycle retire and re-issue keeps the bit.
    pending_nx = (pending_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_nx;
  end

  assign pending      = pending_q;
  assign lu_issue_ok  = !reset && issue_ok_raw;
  assign hazard_stall = !reset &&
                        (src_hazard(rd_reg_1, pending_q, lu_xfer, lu_reg) ||
                         src_hazard(rd_reg_2, pending_q, lu_xfer, lu_reg));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register-file write port between the
// in-order writeback (WB) and the long-latency unit (LU). WB normally wins;
// an LU result refused MAX_WAIT cycles in a row gets a forced grant during
// which wb_hold freezes the WB stage for one cycle.
//   clk, reset    : clock, async active-high reset (all outputs 0 while high)
//   bus           : pipeline-side handshakes (regfile_wb_arbiter_if.slave)
//   rf_write_reg  : register file write index
//   rf_write_data : register file write data
//   rf_reg_write  : register file write enable (never for $zero)
//   pending       : LU scoreboard bits
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus,
  output logic [AW-1:0]        rf_write_reg,
  output logic [DW-1:0]        rf_write_data,
  output logic                 rf_reg_write,
  output logic [NREGS-1:0]     pending
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  arb_state_t    state, state_nx;
  logic [CW-1:0] wait_cnt, wait_cnt_nx;
  logic          wb_hold_q;
  logic          lu_grant;
  logic          lu_xfer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      wb_hold_q <= 1'b0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_cnt_nx;
      wb_hold_q <= (state_nx == FORCE);
    end
  end

  always_comb begin
    lu_grant    = (state == FORCE) || (bus.lu_valid && !bus.wb_valid);
    lu_xfer     = !reset && bus.lu_valid && lu_grant;
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    case (state)
      IDLE: begin
        if (bus.lu_valid && !lu_xfer) begin
          if (MAX_WAIT <= 1) begin
            state_nx = FORCE;
          end else begin
            state_nx    = WAIT;
            wait_cnt_nx = CW'(1);
          end
        end
      end
      WAIT: begin
        if (lu_xfer || !bus.lu_valid) begin
          state_nx    = IDLE;
          wait_cnt_nx = '0;
        end else if (wait_cnt >= CW'(MAX_WAIT - 1)) begin
          // This refusal is the MAX_WAIT-th in a row.
          state_nx    = FORCE;
          wait_cnt_nx = '0;
        end else begin
          wait_cnt_nx = wait_cnt + CW'(1);
        end
      end
      FORCE: begin
        state_nx    = IDLE;
        wait_cnt_nx = '0;
      end
      default: begin
        state_nx    = IDLE;
        wait_cnt_nx = '0;
      end
    endcase
  end

  always_comb begin
    rf_write_reg  = '0;
    rf_write_data = '0;
    rf_reg_write  = 1'b0;
    if (lu_xfer) begin
      rf_write_reg  = bus.lu_reg;
      rf_write_data = bus.lu_data;
      rf_reg_write  = (bus.lu_reg != REG_ZERO);
    end else if (!reset && !lu_grant && bus.wb_valid) begin
      rf_write_reg  = bus.wb_reg;
      rf_write_data = bus.wb_data;
      rf_reg_write  = (bus.wb_reg != REG_ZERO);
    end
  end

  assign bus.wb_hold  = wb_hold_q;
  assign bus.lu_ready = lu_xfer;

  regfile_scoreboard u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .lu_issue     (bus.lu_issue),
    .lu_issue_reg (bus.lu_issue_reg),
    .lu_xfer      (lu_xfer),
    .lu_reg       (bus.lu_reg),
    .rd_reg_1     (bus.rd_reg_1),
    .rd_reg_2     (bus.rd_reg_2),
    .pending      (pending),
    .lu_issue_ok  (bus.lu_issue_ok),
    .hazard_stall (bus.hazard_stall)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios followed by random traffic, all
// checked against a behavioural model (pending set, refusal counter).
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int MAX_WAIT = 4;
  localparam int N_RAND   = 3000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bif();
  logic [AW-1:0]    rf_write_reg;
  logic [DW-1:0]    rf_write_data;
  logic             rf_reg_write;
  logic [NREGS-1:0] pending;

  regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bif),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .rf_reg_write  (rf_reg_write),
    .pending       (pending)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: set of registers with an outstanding LU write, and the
  // number of consecutive cycles the current LU result has been refused.
  bit  mp[NREGS];
  bit  nmp[NREGS];
  int  denied, ndenied;
  bit  lu_hold;   // current LU result must be held next cycle
  bit  last_xfer;

  function automatic logic [NREGS-1:0] mp_vec();
    logic [NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) v[i] = mp[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) mp[i] = 1'b0;
    denied  = 0;
    lu_hold = 1'b0;
  endtask

  task automatic idle();
    bif.wb_valid = 0; bif.wb_reg = '0; bif.wb_data = '0;
    bif.lu_issue = 0; bif.lu_issue_reg = '0;
    bif.lu_valid = 0; bif.lu_reg = '0; bif.lu_data = '0;
    bif.rd_reg_1 = '0; bif.rd_reg_2 = '0;
  endtask

  // Sample at the falling edge, compare everything with the model and
  // prepare the model's next state.
  task automatic check_cycle();
    bit forced, lu_win, xfer, e_we, ok, haz;
    logic [AW-1:0] e_reg;
    logic [DW-1:0] e_data;
    @(negedge clk);
    forced = (denied >= MAX_WAIT);
    lu_win = forced || (bif.lu_valid && !bif.wb_valid);
    xfer   = bif.lu_valid && lu_win;
    e_we = 0; e_reg = '0; e_data = '0;
    if (xfer) begin
      e_reg = bif.lu_reg; e_data = bif.lu_data; e_we = (bif.lu_reg != 0);
    end else if (!lu_win && bif.wb_valid) begin
      e_reg = bif.wb_reg; e_data = bif.wb_data; e_we = (bif.wb_reg != 0);
    end
    ok  = (bif.lu_issue_reg == 0) || !mp[bif.lu_issue_reg] ||
          (xfer && bif.lu_reg == bif.lu_issue_reg);
    haz = 0;
    if (bif.rd_reg_1 != 0 && mp[bif.rd_reg_1] && !(xfer && bif.lu_reg == bif.rd_reg_1)) haz = 1;
    if (bif.rd_reg_2 != 0 && mp[bif.rd_reg_2] && !(xfer && bif.lu_reg == bif.rd_reg_2)) haz = 1;

    chk("wb_hold",       bif.wb_hold, forced);
    chk("lu_ready",      bif.lu_ready, xfer);
    chk("rf_reg_write",  rf_reg_write, e_we);
    chk("rf_write_reg",  rf_write_reg, e_reg);
    chk("rf_write_data", rf_write_data, e_data);
    chk("lu_issue_ok",   bif.lu_issue_ok, ok);
    chk("hazard_stall",  bif.hazard_stall, haz);
    chk("pending",       pending, mp_vec());
    chk("wb_during_hold", bif.wb_valid & bif.wb_hold, 0);
    chk("wb_to_pending",  bif.wb_valid & pending[bif.wb_reg], 0);

    for (int i = 0; i < NREGS; i++) nmp[i] = mp[i];
    if (xfer) nmp[bif.lu_reg] = 1'b0;
    if (bif.lu_issue && ok && bif.lu_issue_reg != 0) nmp[bif.lu_issue_reg] = 1'b1;
    if (forced)                      ndenied = 0;
    else if (bif.lu_valid && !xfer)  ndenied = denied + 1;
    else                             ndenied = 0;
    lu_hold   = bif.lu_valid && !xfer;
    last_xfer = xfer;
  endtask

  task automatic advance();
    @(posedge clk);
    for (int i = 0; i < NREGS; i++) mp[i] = nmp[i];
    denied = ndenied;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb_hold"},  bif.wb_hold, 0);
    chk({tag, "_lu_ready"}, bif.lu_ready, 0);
    chk({tag, "_issue_ok"}, bif.lu_issue_ok, 0);
    chk({tag, "_hazard"},   bif.hazard_stall, 0);
    chk({tag, "_rf_we"},    rf_reg_write, 0);
    chk({tag, "_rf_reg"},   rf_write_reg, 0);
    chk({tag, "_rf_data"},  rf_write_data, 0);
    chk({tag, "_pending"},  pending, 0);
  endtask

  task automatic rand_inputs();
    if (!lu_hold) begin
      bif.lu_valid = ($urandom_range(0, 2) != 0);
      bif.lu_reg   = AW'($urandom_range(0, 15));
      bif.lu_data  = $urandom;
    end
    bif.wb_reg   = AW'($urandom_range(0, 31));
    bif.wb_data  = $urandom;
    bif.wb_valid = (denied < MAX_WAIT) && ($urandom_range(0, 1) == 1) && !mp[bif.wb_reg];
    bif.lu_issue     = ($urandom_range(0, 1) == 1);
    bif.lu_issue_reg = AW'($urandom_range(0, 15));
    bif.rd_reg_1     = AW'($urandom_range(0, 15));
    bif.rd_reg_2     = AW'($urandom_range(0, 15));
  endtask

  initial begin
    model_reset();
    idle();
    reset = 1'b1;
    bif.lu_valid = 1; bif.lu_reg = 5'd3; bif.wb_valid = 0;
    bif.lu_issue = 1; bif.lu_issue_reg = 5'd4;
    @(negedge clk);
    chk_all_zero("in_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    check_cycle();
    chk("rst_pending", pending, 0);
    chk("rst_wb_hold", bif.wb_hold, 0);
    advance();

    // Single writers
    bif.wb_valid = 1; bif.wb_reg = 5'd8; bif.wb_data = 32'hDEADBEEF;
    check_cycle();
    chk("t1_wb_we",   rf_reg_write, 1);
    chk("t1_wb_reg",  rf_write_reg, 8);
    chk("t1_wb_data", rf_write_data, 32'hDEADBEEF);
    advance();
    idle();
    bif.lu_valid = 1; bif.lu_reg = 5'd2; bif.lu_data = 32'd5;
    check_cycle();
    chk("t1_lu_ready", bif.lu_ready, 1);
    chk("t1_lu_reg",   rf_write_reg, 2);
    advance();

    // Starvation: four refusals, forced grant on the fifth cycle
    idle();
    bif.lu_valid = 1; bif.lu_reg = 5'd3; bif.lu_data = 32'hCAFE;
    bif.wb_valid = 1; bif.wb_reg = 5'd4; bif.wb_data = 32'h44;
    for (int i = 1; i <= 4; i++) begin
      check_cycle();
      chk("t2_refused", bif.lu_ready, 0);
      chk("t2_no_hold", bif.wb_hold, 0);
      advance();
    end
    bif.wb_valid = 0;
    check_cycle();
    chk("t2_hold",     bif.wb_hold, 1);
    chk("t2_forced",   bif.lu_ready, 1);
    chk("t2_force_rg", rf_write_reg, 3);
    advance();
    bif.lu_valid = 0; bif.wb_valid = 1;
    check_cycle();
    chk("t2_hold_off", bif.wb_hold, 0);
    chk("t2_wb_again", rf_write_reg, 4);
    advance();

    // Scoreboard and hazard on r9
    idle();
    bif.lu_issue = 1; bif.lu_issue_reg = 5'd9;
    check_cycle();
    chk("t3_issue_ok", bif.lu_issue_ok, 1);
    advance();
    idle(); bif.rd_reg_1 = 5'd9;
    check_cycle();
    chk("t3_pend9", pending[9], 1);
    chk("t3_stall", bif.hazard_stall, 1);
    advance();
    bif.lu_valid = 1; bif.lu_reg = 5'd9; bif.lu_data = 32'h99;
    check_cycle();
    chk("t3_fwd_nostall", bif.hazard_stall, 0);
    advance();
    bif.lu_valid = 0;
    check_cycle();
    chk("t3_pend9_clr", pending[9], 0);
    chk("t3_stall_clr", bif.hazard_stall, 0);
    advance();

    // WAW on r9
    idle();
    bif.lu_issue = 1; bif.lu_issue_reg = 5'd9;
    check_cycle();
    advance();
    check_cycle();
    chk("t4_waw_block", bif.lu_issue_ok, 0);
    advance();
    bif.lu_valid = 1; bif.lu_reg = 5'd9; bif.lu_data = 32'h1;
    check_cycle();
    chk("t4_waw_xfer_ok", bif.lu_issue_ok, 1);
    advance();
    idle();
    check_cycle();
    chk("t4_pend9_kept", pending[9], 1);
    advance();
    bif.lu_valid = 1; bif.lu_reg = 5'd9;
    check_cycle();
    advance();

    // Zero register
    idle();
    bif.lu_valid = 1; bif.lu_reg = 5'd0; bif.lu_data = 32'h1234;
    bif.lu_issue = 1; bif.lu_issue_reg = 5'd0;
    check_cycle();
    chk("t5_ready", bif.lu_ready, 1);
    chk("t5_no_we", rf_reg_write, 0);
    advance();
    idle();
    check_cycle();
    chk("t5_pending", pending, 0);
    chk("t5_nostall", bif.hazard_stall, 0);
    advance();

    // Reset mid-operation
    bif.lu_issue = 1; bif.lu_issue_reg = 5'd2;
    check_cycle(); advance();
    bif.lu_issue_reg = 5'd9;
    check_cycle(); advance();
    idle();
    bif.lu_valid = 1; bif.lu_reg = 5'd5; bif.lu_data = 32'h55;
    bif.wb_valid = 1; bif.wb_reg = 5'd7; bif.wb_data = 32'h77;
    check_cycle(); advance();
    bif.rd_reg_1 = 5'd9;
    check_cycle();
    chk("t6_pending_pre", pending, 32'h00000204);
    #2 reset = 1'b1;
    #1 chk_all_zero("t6_async");
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    idle();
    check_cycle();
    chk("t6_pending_post", pending, 0);
    chk("t6_hold_post", bif.wb_hold, 0);
    advance();
    bif.lu_valid = 1; bif.lu_reg = 5'd6; bif.wb_valid = 1; bif.wb_reg = 5'd7;
    check_cycle(); advance();
    check_cycle();
    chk("t6_idle_after", bif.wb_hold, 0);
    advance();

    // Random traffic
    for (int n = 0; n < N_RAND; n++) begin
      rand_inputs();
      check_cycle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single register-file write port and shares it between two writers.
- Writer 1 is the in-order pipeline writeback (WB). Writer 2 is the long-latency unit (LU: mult/div, loads).
- Keeps a 32-entry pending-write scoreboard for LU destinations and drives the decode hazard stall.
- Bounds LU starvation by forcing a one-cycle WB hold.

Parameters:
NREGS, 32, number of architectural registers
AW, 5, register index width
DW, 32, data width
MAX_WAIT, 4, max cycles an LU result waits before a forced grant (>=1)

Ports:
clk  in  1  system clock, posedge
reset  in  1  asynchronous, active-high reset
wb_valid  in  1  pipeline writeback request
wb_reg  in  AW  WB destination
wb_data  in  DW  WB data
wb_hold  out  1  registered; pipeline must deassert wb_valid (freeze WB stage) while high
lu_issue  in  1  decode issues an LU op
lu_issue_reg  in  AW  LU op destination
lu_issue_ok  out  1  issue permitted (no WAW on pending dest)
lu_valid  in  1  LU result ready
lu_reg  in  AW  LU result destination
lu_data  in  DW  LU result data
lu_ready  out  1  LU result accepted this cycle
rd_reg_1  in  AW  decode source 1
rd_reg_2  in  AW  decode source 2
hazard_stall  out  1  decode must stall (source pending)
rf_write_reg  out  AW  to register file write_reg
rf_write_data  out  DW  to register file write_data
rf_reg_write  out  1  to register file reg_write
pending  out  NREGS  scoreboard bits (debug/verification)

Behaviour:
- Reset (async, active-high): pending=0, FSM=IDLE, wait_cnt=0.
  - While reset is high, all outputs are 0.
  - Reset mid-operation discards scoreboard state; the system flushes any in-flight LU op.
- Arbitration (combinational, same cycle):
  - Grant LU when FSM=FORCE, or when lu_valid && !wb_valid.
  - Otherwise WB wins.
  - lu_ready = lu_valid && LU granted.
- Write port:
  - Drives the granted writer's reg/data.
  - rf_reg_write = granted valid && reg != 0.
  - Writes to $zero complete their handshake but never assert rf_reg_write.
  - With no valid writer, rf_* = 0.
- LU handshake:
  - Transfer = lu_valid && lu_ready.
  - LU holds lu_reg/lu_data stable while lu_valid && !lu_ready.
- FSM:
  - IDLE -> WAIT: lu_valid && !lu_ready; wait_cnt = 1.
  - WAIT -> IDLE: on transfer; wait_cnt = 0.
  - WAIT, no transfer: wait_cnt++. When wait_cnt == MAX_WAIT, go to FORCE.
  - FORCE: wb_hold = 1 for exactly one cycle; LU is granted unconditionally; next state is IDLE, wait_cnt = 0.
  - wb_valid high during FORCE is a protocol violation: WB is not written, and the bench asserts it never happens.
  - wb_hold is a registered decode of FSM=FORCE, so there is no combinational path from wb_valid.
- Scoreboard:
  - Set pending[r] on lu_issue && lu_issue_ok, for r != 0.
  - Clear pending[lu_reg] on transfer.
  - Same-cycle clear and set of the same r: the bit stays 1.
- lu_issue_ok = !pending[lu_issue_reg] || (transfer && lu_reg == lu_issue_reg). Always 1 for r = 0.
- hazard_stall:
  - 1 if either nonzero rd_reg_x has its pending bit set.
  - Exception: a source being written by an LU transfer this cycle does not stall, because the register file forwards write_data on a matching index.
- Invariant: the pipeline never writes a pending register via WB; the bench asserts this.
- Latency: all write-port, handshake and stall outputs are 0-cycle (combinational from inputs and state). Scoreboard updates are visible the next cycle.

Decomposition:
- Package regfile_pkg holds:
  - AW, DW, NREGS
  - REG_ZERO = 0, REG_RA = 31
  - FSM state enum {IDLE, WAIT, FORCE}
- Sub-module regfile_scoreboard holds:
  - the pending vector
  - set/clear logic
  - lu_issue_ok and the hazard compare
- Arbiter FSM and write-port mux stay in the top module.

Test Plan:
1. Single writers: wb_valid=1, wb_reg=8, wb_data=0xDEADBEEF with lu idle -> rf_reg_write=1, rf_write_reg=8, rf_write_data=0xDEADBEEF same cycle. Then lu_valid=1, lu_reg=2, lu_data=5 with wb idle -> lu_ready=1, rf_write_reg=2.
2. Starvation: lu_valid held, wb_valid=1 every cycle, MAX_WAIT=4 -> lu_ready=0 for 4 cycles, wb_hold=1 in cycle 5, LU written in cycle 5; wb_hold=0 and FSM=IDLE in cycle 6.
3. Scoreboard/hazard: issue LU to r9, then rd_reg_1=9 -> pending[9]=1, hazard_stall=1. On the LU transfer cycle to r9 -> hazard_stall=0; next cycle pending[9]=0.
4. WAW: pending[9]=1 and lu_issue_reg=9 without transfer -> lu_issue_ok=0. Same request in the cycle of the r9 transfer -> lu_issue_ok=1 and pending[9] remains 1.
5. Zero register: lu transfer to r0 data 0x1234 -> lu_ready=1, rf_reg_write=0. LU issue to r0 -> pending stays 0, hazard_stall=0 for rd_reg_1=0.
6. Reset mid-operation: pending=0x00000204, FSM=WAIT, assert reset asynchronously between edges -> all outputs 0 immediately. After release: pending=0, FSM=IDLE, wb_hold=0.
